framebuffer_ctrl: RTL and testbench
===================================

// Module: framebuffer_ctrl
// PURPOSE
// Double-buffered palette-index framebuffer sitting directly upstream of the VGA output stage.
// A drawing engine writes pixels into the back buffer over a valid/ready port.
// The output stage reads the front buffer with 1-cycle latency.
// Buffers swap only on the output stage's new_frame pulse, and only when the drawer requests it.
// After each swap a clear engine zeroes the new back buffer (index 0 = "transparent/keep last seen").
// PARAMETERS
// H_PIX    320  pixels per line (read/write x range 0..H_PIX-1)
// V_PIX    240  lines per frame (read/write y range 0..V_PIX-1)
// COLOR_W  3    palette index width
// PORTS
// Clk                 in   1        system clock
// Reset               in   1        synchronous, active-high reset
// new_frame           in   1        1-cycle pulse per frame from output stage; swap point
// framebuffer_coords  in   17       screenXY {x[8:0], y[7:0]}; front-buffer read address
// framebuffer_output  out  COLOR_W  front-buffer pixel at coords presented 1 cycle earlier
// wr_valid            in   1        drawer presents a pixel write
// wr_ready            out  1        write accepted this cycle when wr_valid & wr_ready
// wr_x                in   9        write x
// wr_y                in   8        write y
// wr_color            in   COLOR_W  write palette index
// swap_req            in   1        level; drawer done with back buffer, hold until swap_ack
// swap_ack            out  1        1-cycle pulse in the cycle the swap takes effect
// clear_busy          out  1        high while the clear engine runs
// BEHAVIOUR
// - Storage: two banks of H_PIX*V_PIX entries; addr = y*H_PIX + x (shift-add for 320: y<<8 + y<<6 + x).
// - Register front_sel selects the read bank; the write/clear bank is ~front_sel.
// - Read: framebuffer_output is registered, 1-cycle latency, every cycle regardless of state.
//   Out-of-range coords (x>=H_PIX or y>=V_PIX) return 0.
//   Returns 0 until the first swap after reset (front_valid=0).
// - FSM states:
//   CLEAR: clr_addr 0..H_PIX*V_PIX-1, one zero write per cycle to the back bank.
//     Goes to DRAW after the last address. Takes exactly H_PIX*V_PIX cycles.
//   DRAW: swap_now = new_frame & swap_req. While swap_now=0, wr_ready=1.
//     When swap_now=1: wr_ready=0 (write not accepted), front_sel toggles, front_valid<=1,
//     swap_ack=1, clr_addr<=0, next state CLEAR.
// - wr_ready = (state==DRAW) & ~swap_now. It is combinational on new_frame/swap_req.
//   The drawer must not depend on wr_ready to drive wr_valid.
// - Writes:
//   Accepted writes land in the back bank on the next clock edge; they are visible after the swap.
//   Accepted out-of-range writes are dropped silently.
//   Writing index 0 is legal and stores 0.
// - swap_req, new_frame and clear interactions:
//   swap_req asserted during CLEAR is held off; no swap_ack until CLEAR ends.
//   The swap then occurs at the first new_frame in DRAW.
//   new_frame in CLEAR, or with swap_req=0, is ignored: front unchanged, frame repeats.
// - The front bank is never written, so no read/write collision is possible within a bank.
// - Reset:
//   front_sel=0, front_valid=0, state=CLEAR, clr_addr=0.
//   Outputs: wr_ready=0, swap_ack=0, clear_busy=1, framebuffer_output=0.
//   Reset mid-CLEAR or mid-DRAW restarts CLEAR of bank 1. Bank 0 contents are don't-care (masked by front_valid).
// - clear_busy = (state==CLEAR). The drawer observes completion as wr_ready rising.
// TESTING
// - Reset, then count cycles -> clear_busy high exactly 76800 cycles, then wr_ready=1.
//   framebuffer_output=0 for any coords.
// - Write (10,20)=5, assert swap_req, pulse new_frame -> swap_ack that cycle.
//   Read (10,20) -> 5 one cycle later; (11,20) -> 0.
// - After swap, read (10,20) during and after the back-bank clear -> still 5 (front untouched).
//   Next swap with no writes -> (10,20) reads 0.
// - swap_req=1 during CLEAR plus new_frame pulses -> no swap_ack until CLEAR done.
//   Swap at the first new_frame after CLEAR.
// - wr_valid=1 with x=320,y=0 and with x=0,y=240 -> accepted (wr_ready=1), nothing stored.
//   Reads of (0,0) after swap = 0.
// - Write held in the new_frame&swap_req cycle -> wr_ready=0, not stored.
//   After CLEAR, the same write is accepted into the new back bank.

Source files
------------

// File: rtl/framebuffer_ctrl_if.sv
// Drawer-side port of the framebuffer: pixel write handshake plus the
// buffer-swap request/acknowledge pair and clear status.
interface framebuffer_ctrl_if #(
  parameter int COLOR_W = 3
);
  logic               wr_valid;
  logic               wr_ready;
  logic [8:0]         wr_x;
  logic [7:0]         wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic               swap_req;
  logic               swap_ack;
  logic               clear_busy;

  // Drawing engine side.
  modport master (
    output wr_valid, wr_x, wr_y, wr_color, swap_req,
    input  wr_ready, swap_ack, clear_busy
  );

  // Framebuffer side.
  modport slave (
    input  wr_valid, wr_x, wr_y, wr_color, swap_req,
    output wr_ready, swap_ack, clear_busy
  );
endinterface

// File: rtl/framebuffer_ctrl.sv
// Double-buffered palette-index framebuffer. The drawer fills the back bank,
// the output stage reads the front bank with one cycle of latency, and the
// banks exchange roles on new_frame while the drawer requests a swap. Every
// swap is followed by a full zero-fill of the new back bank.
module framebuffer_ctrl #(
  parameter int H_PIX   = 320,
  parameter int V_PIX   = 240,
  parameter int COLOR_W = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               new_frame,
  input  logic [16:0]        framebuffer_coords,
  output logic [COLOR_W-1:0] framebuffer_output,
  framebuffer_ctrl_if.slave  drw
);

  localparam int DEPTH = H_PIX * V_PIX;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {S_CLEAR, S_DRAW} state_t;

  state_t              state_reg;
  logic [AW-1:0]       clr_addr_reg;
  logic                front_sel_reg;
  logic                front_valid_reg;
  logic                rd_ok_reg;
  logic                rd_sel_reg;
  logic [2*COLOR_W-1:0] rd_data;

  // Linear pixel address; only meaningful for in-range coordinates.
  function automatic logic [AW-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
    return AW'(y) * AW'(H_PIX) + AW'(x);
  endfunction

  logic [8:0]         rd_x;
  logic [7:0]         rd_y;
  logic               rd_in_range;
  logic [AW-1:0]      rd_addr;
  logic               wr_in_range;
  logic               swap_now;
  logic               wr_fire;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [COLOR_W-1:0] mem_wdata;
  logic               back_sel;

  assign rd_x        = framebuffer_coords[16:8];
  assign rd_y        = framebuffer_coords[7:0];
  assign rd_in_range = (rd_x < 9'(H_PIX)) && (rd_y < 8'(V_PIX));
  // Out-of-range reads are masked at the output; park the address at 0.
  assign rd_addr     = rd_in_range ? pix_addr(rd_x, rd_y) : '0;

  assign wr_in_range = (drw.wr_x < 9'(H_PIX)) && (drw.wr_y < 8'(V_PIX));

  // The swap takes priority over a write presented in the same cycle.
  assign swap_now       = (state_reg == S_DRAW) && new_frame && drw.swap_req;
  assign drw.wr_ready   = (state_reg == S_DRAW) && !(new_frame && drw.swap_req);
  assign drw.swap_ack   = swap_now;
  assign drw.clear_busy = (state_reg == S_CLEAR);

  // Out-of-range writes complete the handshake but never touch memory.
  assign wr_fire   = drw.wr_valid && drw.wr_ready && wr_in_range;
  assign mem_we    = !Reset && ((state_reg == S_CLEAR) || wr_fire);
  assign mem_waddr = (state_reg == S_CLEAR) ? clr_addr_reg : pix_addr(drw.wr_x, drw.wr_y);
  assign mem_wdata = (state_reg == S_CLEAR) ? '0 : drw.wr_color;
  assign back_sel  = !front_sel_reg;

  // Control FSM: zero-fill the back bank, then accept drawing until a swap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= S_CLEAR;
      clr_addr_reg    <= '0;
      front_sel_reg   <= 1'b0;
      front_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_CLEAR: begin
          if (clr_addr_reg == AW'(DEPTH - 1)) begin
            state_reg <= S_DRAW;
          end else begin
            clr_addr_reg <= clr_addr_reg + 1'b1;
          end
        end
        S_DRAW: begin
          if (swap_now) begin
            front_sel_reg   <= !front_sel_reg;
            front_valid_reg <= 1'b1;
            clr_addr_reg    <= '0;
            state_reg       <= S_CLEAR;
          end
        end
        default: state_reg <= S_CLEAR;
      endcase
    end
  end

  // Read qualifiers travel alongside the RAM read so the output mux sees
  // the bank and validity that applied when the coordinates were presented.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_ok_reg  <= 1'b0;
      rd_sel_reg <= 1'b0;
    end else begin
      rd_ok_reg  <= front_valid_reg && rd_in_range;
      rd_sel_reg <= front_sel_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [COLOR_W-1:0] mem [DEPTH];
      logic [COLOR_W-1:0] rd_q;

      // One bank: written only while it is the back bank, read every cycle.
      always_ff @(posedge Clk) begin
        if (mem_we && (back_sel == 1'(gi))) begin
          mem[mem_waddr] <= mem_wdata;
        end
        rd_q <= mem[rd_addr];
      end

      assign rd_data[gi*COLOR_W +: COLOR_W] = rd_q;
    end
  endgenerate

  assign framebuffer_output = !rd_ok_reg ? '0 :
                              rd_sel_reg ? rd_data[2*COLOR_W-1:COLOR_W] : rd_data[COLOR_W-1:0];

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Directed bench for framebuffer_ctrl on a reduced 24x24 raster. A picture-level
// model (front image, back image, clear countdown) is compared with the DUT on
// every cycle; literal expectations pin the model at the interesting points.
module tb_framebuffer_ctrl;
  localparam int H     = 24;
  localparam int V     = 24;
  localparam int C     = 3;
  localparam int DEPTH = H * V;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         new_frame = 1'b0;
  logic [16:0]  coords = '0;
  logic [C-1:0] fb_out;

  framebuffer_ctrl_if #(.COLOR_W(C)) drw();

  framebuffer_ctrl #(.H_PIX(H), .V_PIX(V), .COLOR_W(C)) dut (
    .Clk(clk),
    .Reset(rst),
    .new_frame(new_frame),
    .framebuffer_coords(coords),
    .framebuffer_output(fb_out),
    .drw(drw)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] xy(input int x, input int y);
    return {9'(x), 8'(y)};
  endfunction

  // Picture-level model: what the screen shows and what the drawer has drawn.
  int m_front[DEPTH];
  int m_back[DEPTH];
  int m_busy = DEPTH;
  bit m_valid = 1'b0;
  int m_out = 0;
  bit m_live = 1'b0;
  int rx, ry, wx, wy;

  always @(posedge clk) begin
    rx = int'(coords[16:8]);
    ry = int'(coords[7:0]);
    wx = int'(drw.wr_x);
    wy = int'(drw.wr_y);
    m_live = 1'b1;
    if (rst) begin
      m_busy  = DEPTH;
      m_valid = 1'b0;
      m_out   = 0;
      foreach (m_back[i]) m_back[i] = 0;
    end else begin
      m_out = (m_valid && rx < H && ry < V) ? m_front[ry * H + rx] : 0;
      if (m_busy > 0) begin
        m_busy--;
      end else if (new_frame && drw.swap_req) begin
        m_front = m_back;
        foreach (m_back[i]) m_back[i] = 0;
        m_valid = 1'b1;
        m_busy  = DEPTH;
      end else if (drw.wr_valid && wx < H && wy < V) begin
        m_back[wy * H + wx] = int'(drw.wr_color);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  bit c_idle, c_swap;
  always @(negedge clk) begin
    if (m_live) begin
      c_idle = (m_busy == 0);
      c_swap = c_idle && new_frame && drw.swap_req;
      chk("cyc_clear_busy", int'(drw.clear_busy), int'(!c_idle));
      chk("cyc_wr_ready",   int'(drw.wr_ready),   int'(c_idle && !c_swap));
      chk("cyc_swap_ack",   int'(drw.swap_ack),   int'(c_swap));
      chk("cyc_output",     int'(fb_out),         m_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear();
    int n = 0;
    while (drw.clear_busy && n < 2 * DEPTH) begin
      step();
      n++;
    end
    chk("clear_done", int'(drw.clear_busy), 0);
  endtask

  int cnt;
  int oor_x[5] = '{24, 0, 320, 23, 30};
  int oor_y[5] = '{0, 24, 0, 23, 255};

  initial begin
    drw.wr_valid = 1'b0;
    drw.wr_x     = '0;
    drw.wr_y     = '0;
    drw.wr_color = '0;
    drw.swap_req = 1'b0;
    repeat (3) step();
    chk("reset_clear_busy", int'(drw.clear_busy), 1);
    chk("reset_wr_ready",   int'(drw.wr_ready),   0);
    chk("reset_swap_ack",   int'(drw.swap_ack),   0);
    chk("reset_output",     int'(fb_out),         0);

    // Initial clear: length, and blank output at any coordinates.
    rst = 1'b0;
    cnt = 0;
    while (drw.clear_busy && cnt < 2 * DEPTH) begin
      coords = xy(cnt % 30, cnt % 26);
      cnt++;
      step();
    end
    chk("clear_cycles", cnt, 576);
    chk("ready_after_clear", int'(drw.wr_ready), 1);
    chk("blank_before_swap", int'(fb_out), 0);

    // Draw one pixel and swap it to the front.
    drw.wr_valid = 1'b1; drw.wr_x = 9'd10; drw.wr_y = 8'd20; drw.wr_color = 3'd5;
    #1 chk("wr_ready_draw", int'(drw.wr_ready), 1);
    step();
    drw.wr_valid = 1'b0;
    drw.swap_req = 1'b1; new_frame = 1'b1; coords = xy(10, 20);
    #1 chk("swap_ack_pulse", int'(drw.swap_ack), 1);
    step();
    new_frame = 1'b0; drw.swap_req = 1'b0;
    chk("read_presented_pre_swap", int'(fb_out), 0);
    step();
    chk("read_10_20", int'(fb_out), 5);
    coords = xy(11, 20);
    step();
    chk("read_11_20", int'(fb_out), 0);

    // Front survives the back-bank clear; swap requests wait for it to end.
    coords = xy(10, 20);
    drw.swap_req = 1'b1;
    cnt = 0;
    while (drw.clear_busy && cnt < 2 * DEPTH) begin
      new_frame = (cnt % 100 == 50);
      #1 chk("ack_held_off", int'(drw.swap_ack), 0);
      step();
      if (cnt > 0) chk("front_kept", int'(fb_out), 5);
      cnt++;
    end
    chk("clear2_done", int'(drw.clear_busy), 0);
    new_frame = 1'b1;
    #1 chk("swap_ack_after_clear", int'(drw.swap_ack), 1);
    chk("front_before_empty_swap", int'(fb_out), 5);
    step();
    new_frame = 1'b0; drw.swap_req = 1'b0;
    step();
    chk("read_after_empty_swap", int'(fb_out), 0);

    // Out-of-range writes are accepted but store nothing.
    wait_clear();
    for (int i = 0; i < 5; i++) begin
      drw.wr_valid = 1'b1; drw.wr_x = 9'(oor_x[i]); drw.wr_y = 8'(oor_y[i]); drw.wr_color = 3'd7;
      #1 chk("oor_wr_ready", int'(drw.wr_ready), 1);
      step();
    end
    drw.wr_valid = 1'b0;
    drw.swap_req = 1'b1; new_frame = 1'b1; coords = xy(0, 0);
    step();
    new_frame = 1'b0; drw.swap_req = 1'b0;
    step();
    chk("oor_read_0_0", int'(fb_out), 0);
    coords = xy(0, 1);
    step();
    chk("oor_read_0_1", int'(fb_out), 0);
    coords = xy(23, 23);
    step();
    chk("inrange_read_23_23", int'(fb_out), 7);

    // A write held across the swap cycle is refused, then taken after the clear.
    wait_clear();
    drw.wr_valid = 1'b1; drw.wr_x = 9'd3; drw.wr_y = 8'd4; drw.wr_color = 3'd6;
    drw.swap_req = 1'b1; new_frame = 1'b1; coords = xy(3, 4);
    #1 chk("held_wr_ready", int'(drw.wr_ready), 0);
    step();
    new_frame = 1'b0; drw.swap_req = 1'b0;
    step();
    chk("held_not_in_front", int'(fb_out), 0);
    wait_clear();
    chk("held_accepted_ready", int'(drw.wr_ready), 1);
    step();
    drw.wr_valid = 1'b0;
    drw.swap_req = 1'b1; new_frame = 1'b1;
    step();
    new_frame = 1'b0; drw.swap_req = 1'b0;
    step();
    chk("held_write_visible", int'(fb_out), 6);

    // Reset in DRAW restarts the clear and blanks the output.
    rst = 1'b1;
    step();
    chk("mid_reset_output", int'(fb_out), 0);
    chk("mid_reset_clear_busy", int'(drw.clear_busy), 1);
    rst = 1'b0;
    step();
    chk("post_reset_output", int'(fb_out), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
